eth_frame_gen: RTL and testbench

Synthesizable, parametrised Ethernet traffic source for switch bring-up and pause/throughput cost measurement. Emits complete GMII-style frames (preamble, SFD, DA, SA, payload, FCS) on an 8-bit dv/er/data stream. Destination port rotates over N_PORTS, and each frame carries a running sequence number. Frame length, inter-frame gap, length-sweep mode, error injection and FCS corruption are all runtime-controlled. Drives one switch ingress port in place of a PHY.

---
 rtl/eth_pkg.sv | 34 +++
 rtl/eth_fcs_gen.sv | 43 ++++
 rtl/eth_frame_gen.sv | 211 +++++++++++++++++++++
 tb/tb_eth_frame_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and the byte-wide CRC-32 update for the
// Ethernet frame generator and its FCS block.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam int unsigned MIN_FRAME   = 64;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StBody,
    StFcs,
    StGap
  } state_e;

  // MSB-first register, data bits fed LSB first (Ethernet bit order).
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) begin
        c = {c[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_gen.sv
// Running CRC-32 over a byte stream; fcs holds the wire FCS with byte 0 in
// bits [7:0] (bit-reversed, complemented CRC register).
module eth_fcs_gen
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc,
  output logic [31:0] fcs
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_d8(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  always_comb begin
    fcs = '0;
    for (int i = 0; i < 32; i++) begin
      fcs[i] = ~crc_q[31-i];
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_frame_gen.sv
// GMII-style Ethernet traffic source: preamble, rotating-port/sequence body,
// FCS and gap, with runtime length, gap, sweep and error controls.
module eth_frame_gen
  import eth_pkg::*;
#(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_IFG = 12,
  parameter int unsigned SEQ_W   = 16,
  localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LW-1:0]    cfg_len,
  input  logic [7:0]       cfg_ifg,
  input  logic             cfg_sweep,
  input  logic             cfg_bad_fcs,
  input  logic             err_inject,
  output logic             dv,
  output logic             er,
  output logic [7:0]       data,
  output logic             busy,
  output logic [SEQ_W-1:0] seq
);

  localparam int unsigned CW       = (LW > 8) ? LW : 8;
  localparam int unsigned SB       = SEQ_W / 8;
  localparam logic [LW-1:0] MinLen = LW'(MIN_FRAME);
  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);
  localparam logic [7:0] MinIfg    = 8'(MIN_IFG);
  localparam logic [7:0] LastPort  = 8'(N_PORTS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic [7:0]       ifg_q, ifg_d;
  logic             bad_q, bad_d;
  logic             arm_q, arm_d;
  logic             erf_q, erf_d;
  logic [7:0]       port_q, port_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             dv_q, dv_d;
  logic             er_q, er_d;
  logic [7:0]       data_q, data_d;

  logic             start;
  logic [LW-1:0]    len_clamp;
  logic [7:0]       ifg_eff;
  logic             crc_init, crc_en;
  logic [31:0]      crc, fcs;
  logic [CW-1:0]    k;
  logic [SEQ_W-1:0] seq_sh;
  logic [31:0]      unused_crc;

  assign len_clamp  = (cfg_len < MinLen) ? MinLen : ((cfg_len > MaxLen) ? MaxLen : cfg_len);
  assign ifg_eff    = (cfg_ifg < MinIfg) ? MinIfg : cfg_ifg;
  assign unused_crc = crc;

  // Next-state and per-frame configuration latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ifg_d   = ifg_q;
    bad_d   = bad_q;
    erf_d   = erf_q;
    port_d  = port_q;
    seq_d   = seq_q;
    arm_d   = arm_q | err_inject;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) start = 1'b1;
      end
      StPre: begin
        if (cnt_q == CW'(7)) begin
          state_d = StBody;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StBody: begin
        if (cnt_q == CW'(len_q) - CW'(5)) begin
          state_d = StFcs;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFcs: begin
        if (cnt_q == CW'(3)) begin
          state_d = StGap;
          cnt_d   = '0;
          port_d  = (port_q == LastPort) ? 8'd1 : port_q + 8'd1;
          seq_d   = seq_q + SEQ_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CW'(ifg_q) - CW'(1)) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StPre;
      cnt_d   = '0;
      ifg_d   = ifg_eff;
      bad_d   = cfg_bad_fcs;
      erf_d   = arm_q;
      arm_d   = err_inject;
      if (cfg_sweep) begin
        len_d = (state_q == StIdle || len_q >= len_clamp) ? MinLen : len_q + LW'(1);
      end else begin
        len_d = len_clamp;
      end
    end
  end

  // Output byte for the state being entered; registered on the same edge.
  always_comb begin
    dv_d     = 1'b0;
    er_d     = 1'b0;
    data_d   = '0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    k        = CW'(len_q) - CW'(5) - cnt_d;
    seq_sh   = seq_q >> {k, 3'b000};
    unique case (state_d)
      StPre: begin
        dv_d     = 1'b1;
        data_d   = (cnt_d == CW'(7)) ? SFD : PREAMBLE;
        crc_init = 1'b1;
      end
      StBody: begin
        dv_d   = 1'b1;
        crc_en = 1'b1;
        if (cnt_d < CW'(2)) begin
          data_d = port_q;
        end else if (k < CW'(SB)) begin
          data_d = seq_sh[7:0];
        end
        er_d = erf_q && (cnt_d == CW'(12));
      end
      StFcs: begin
        dv_d   = 1'b1;
        data_d = fcs[{cnt_d[1:0], 3'b000} +: 8] ^ {8{bad_q && (cnt_d == '0)}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= MinLen;
      ifg_q   <= MinIfg;
      bad_q   <= 1'b0;
      arm_q   <= 1'b0;
      erf_q   <= 1'b0;
      port_q  <= 8'd1;
      seq_q   <= '0;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ifg_q   <= ifg_d;
      bad_q   <= bad_d;
      arm_q   <= arm_d;
      erf_q   <= erf_d;
      port_q  <= port_d;
      seq_q   <= seq_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      data_q  <= data_d;
    end
  end

  eth_fcs_gen u_fcs (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .din   (data_d),
    .crc   (crc),
    .fcs   (fcs)
  );

  assign dv   = dv_q;
  assign er   = er_q;
  assign data = data_q;
  assign busy = (state_q != StIdle);
  assign seq  = seq_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed and randomized checks of eth_frame_gen against a frame-level
// reference model (reflected CRC-32, port/sequence bookkeeping).
module tb_eth_frame_gen;

  localparam int unsigned NP = 3;
  localparam int unsigned ML = 1518;
  localparam int unsigned MI = 12;
  localparam int unsigned SW = 16;
  localparam int unsigned LW = $clog2(ML + 1);
  localparam int NF = 40;
  localparam int MB = 1600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] cfg_len = LW'(64);
  logic [7:0]    cfg_ifg = 8'd12;
  logic          cfg_sweep = 1'b0;
  logic          cfg_bad_fcs = 1'b0;
  logic          err_inject = 1'b0;
  logic          dv, er, busy;
  logic [7:0]    data;
  logic [SW-1:0] seq;

  eth_frame_gen #(
    .N_PORTS (NP),
    .MAX_LEN (ML),
    .MIN_IFG (MI),
    .SEQ_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_len     (cfg_len),
    .cfg_ifg     (cfg_ifg),
    .cfg_sweep   (cfg_sweep),
    .cfg_bad_fcs (cfg_bad_fcs),
    .err_inject  (err_inject),
    .dv          (dv),
    .er          (er),
    .data        (data),
    .busy        (busy),
    .seq         (seq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_port = 1;
  int m_seq = 0;

  // Frame capture
  logic [7:0] fb [NF][MB];
  int flen [NF];
  int fer_cnt [NF];
  int fer_pos [NF];
  int fgap [NF];
  int nstart = 0;
  int nfr = 0;
  int cur_len = 0;
  int slot = 0;
  bit in_frame = 1'b0;
  bit gap_open = 1'b0;

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        gap_open = 1'b0;
        cur_len  = 0;
        slot     = (nstart < NF) ? nstart : NF - 1;
        fer_cnt[slot] = 0;
        fer_pos[slot] = -1;
        fgap[slot]    = 0;
        nstart++;
      end
      if (cur_len < MB) fb[slot][cur_len] = data;
      if (er === 1'b1) begin
        fer_cnt[slot]++;
        fer_pos[slot] = cur_len;
      end
      cur_len++;
    end else begin
      if (in_frame) begin
        in_frame   = 1'b0;
        flen[slot] = cur_len;
        nfr++;
        gap_open = 1'b1;
      end
      if (gap_open && busy === 1'b1) fgap[slot]++;
      if (busy !== 1'b1) gap_open = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int clampl(input int l);
    if (l < 64) return 64;
    if (l > int'(ML)) return int'(ML);
    return l;
  endfunction

  function automatic logic [7:0] body_b(input int port, input int s, input int len, input int b);
    int k;
    if (b < 2) return 8'(port);
    k = len - 5 - b;
    if (k < int'(SW / 8)) return 8'(s >> (8 * k));
    return 8'h00;
  endfunction

  function automatic logic [31:0] fcs_of(input int port, input int s, input int len);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int b = 0; b < len - 4; b++) begin
      r ^= {24'h0, body_b(port, s, len, b)};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic check_frame(input int idx, input int len, input bit bad, input int gap,
                             input int erpos);
    logic [31:0] f, r, rv;
    logic [7:0]  e;
    int          mism;
    f    = fcs_of(m_port, m_seq, len);
    mism = 0;
    for (int j = 0; j < 8 + len; j++) begin
      if (j < 7) e = 8'h55;
      else if (j == 7) e = 8'hD5;
      else if (j < len + 4) e = body_b(m_port, m_seq, len, j - 8);
      else e = f[8*(j-len-4) +: 8] ^ ((bad && j == len + 4) ? 8'hFF : 8'h00);
      if (j < MB && fb[idx][j] !== e) mism++;
    end
    chk("frame_len", 32'(flen[idx]), 32'(8 + len));
    chk("byte_mismatches", 32'(mism), 32'd0);
    chk("da_port", {24'h0, fb[idx][8]}, 32'(m_port));
    chk("seq_field", {16'h0, fb[idx][len+2], fb[idx][len+3]}, 32'(m_seq & 16'hFFFF));
    if (!bad) begin
      r = 32'hFFFFFFFF;
      for (int j = 8; j < 8 + len; j++) begin
        r ^= {24'h0, fb[idx][j]};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      for (int b = 0; b < 32; b++) rv[b] = r[31-b];
      chk("crc_residue", rv, 32'hC704DD7B);
    end else begin
      chk("fcs0_inverted", {24'h0, fb[idx][len+4]}, {24'h0, f[7:0] ^ 8'hFF});
    end
    chk("er_count", 32'(fer_cnt[idx]), (erpos >= 0) ? 32'd1 : 32'd0);
    chk("er_pos", 32'(fer_pos[idx]), 32'(erpos));
    chk("gap", 32'(fgap[idx]), 32'(gap));
    m_seq++;
    m_port = (m_port == int'(NP)) ? 1 : m_port + 1;
  endtask

  task automatic run(input int n, input int len, input int ifg, input bit bad, input bit sweep,
                     input int err_at);
    int base, plen, l, t;
    cfg_len     = LW'(len);
    cfg_ifg     = 8'(ifg);
    cfg_bad_fcs = bad;
    cfg_sweep   = sweep;
    base        = nstart;
    enable      = 1'b1;
    t = 0;
    while (nstart < base + 1 && t < 20000) begin tick(); t++; end
    if (err_at >= 0) begin
      repeat (err_at) tick();
      err_inject = 1'b1;
      tick();
      err_inject = 1'b0;
    end
    while (nstart < base + n && t < 20000) begin tick(); t++; end
    enable = 1'b0;
    while ((busy !== 1'b0 || nfr < base + n) && t < 20000) begin tick(); t++; end
    chk("within_budget", 32'(t < 20000), 32'd1);
    plen = 0;
    for (int i = 0; i < n; i++) begin
      if (sweep) l = (i == 0 || plen >= clampl(len)) ? 64 : plen + 1;
      else l = clampl(len);
      plen = l;
      check_frame(base + i, l, bad, (ifg < int'(MI)) ? int'(MI) : ifg,
                  (err_at >= 0 && i == 1) ? 20 : -1);
    end
    chk("seq_out", {16'h0, seq}, 32'(m_seq & 16'hFFFF));
  endtask

  initial begin
    int base, t;
    repeat (3) tick();
    chk("rst_dv", {31'h0, dv}, 32'd0);
    chk("rst_er", {31'h0, er}, 32'd0);
    chk("rst_data", {24'h0, data}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_seq", {16'h0, seq}, 32'd0);
    rst_n = 1'b1;
    tick();

    run(3, 64, 12, 1'b0, 1'b0, -1);   // basic rotation and sequence
    run(2, 64, 12, 1'b1, 1'b0, -1);   // corrupted FCS byte 0
    run(5, 66, 12, 1'b0, 1'b1, -1);   // length sweep 64,65,66,64,65
    run(2, 70, 12, 1'b0, 1'b0, 30);   // err_inject during frame 0 body
    run(1, 20, 3, 1'b0, 1'b0, -1);    // short length and gap clamped
    run(1, 2000, 12, 1'b0, 1'b0, -1); // long length clamped to MAX_LEN
    for (int r = 0; r < 2; r++) begin
      run(int'($urandom_range(1, 3)), int'($urandom_range(64, 160)),
          int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    // Reset in the middle of a frame
    cfg_len = LW'(64); cfg_ifg = 8'd12; cfg_bad_fcs = 1'b0; cfg_sweep = 1'b0;
    base = nstart;
    enable = 1'b1;
    t = 0;
    while ((nstart < base + 1 || cur_len < 40) && t < 20000) begin tick(); t++; end
    rst_n = 1'b0;
    #1;
    chk("async_rst_dv", {31'h0, dv}, 32'd0);
    chk("async_rst_data", {24'h0, data}, 32'd0);
    tick();
    chk("rst_busy_mid", {31'h0, busy}, 32'd0);
    chk("rst_seq_mid", {16'h0, seq}, 32'd0);
    m_port = 1;
    m_seq  = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_dv", {31'h0, dv}, 32'd1);
    chk("restart_data", {24'h0, data}, 32'h55);
    while (nstart < base + 2 && t < 20000) begin tick(); t++; end
    enable = 1'b0;
    while ((busy !== 1'b0 || nfr < base + 2) && t < 20000) begin tick(); t++; end
    chk("rst_within_budget", 32'(t < 20000), 32'd1);
    chk("truncated_len", 32'(flen[base]), 32'd40);
    check_frame(base + 1, 64, 1'b0, 12, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
